uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UartTx instance between NUM_REQ byte producers (status reporter, debug dump, etc.).
//  Round-robin grant per byte, optional lock for uninterrupted multi-byte messages.
//  Sequences the UartTx handshake: one-cycle write pulse, wait busy rise, wait busy fall.
//  Sits between requesters and UartTx in the top level; replaces ad-hoc per-top write FSMs.
// PARAMETERS
//  NUM_REQ        4   number of requesters (2..8)
//  INDEX_WIDTH    2   width of grant index, >= clog2(NUM_REQ)
//  BUSY_TIMEOUT   15  cycles to wait for uart_busy_i to rise after write pulse
//  TIMEOUT_WIDTH  4   counter width, must hold BUSY_TIMEOUT
// PORTS
//  clock_i          in   1              system clock
//  reset_n_i        in   1              asynchronous active-low reset
//  req_i            in   NUM_REQ        level request, one bit per requester
//  lock_i           in   NUM_REQ        hold grant after current byte while req stays high
//  data_i           in   8*NUM_REQ      byte per requester, requester k at [8k+7:8k]
//  ack_o            out  NUM_REQ        one-cycle pulse: byte of requester k taken
//  done_o           out  1              one-cycle pulse: UartTx finished the byte
//  error_o          out  1              one-cycle pulse: busy never rose (timeout)
//  active_o         out  1              high whenever state != IDLE
//  grant_index_o    out  INDEX_WIDTH    index of current/last granted requester
//  uart_write_o     out  1              to UartTx write_i
//  uart_data_o      out  8              to UartTx data_i, stable from write pulse to done
//  uart_busy_i      in   1              from UartTx busy_o
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, all outputs 0; async assert, sync release. Reset mid-byte
//   drops uart_write_o at once; in-flight byte is abandoned, no ack/done re-issued.
//  IDLE: if |req_i and !uart_busy_i, grant g = first k with req_i[k], scanning rr_ptr,
//   rr_ptr+1, ... wrapping mod NUM_REQ. Next cycle: ISSUE, uart_data_o=data_i[g], grant_index_o=g.
//   If uart_busy_i high in IDLE, no grant (external busy is respected).
//  ISSUE (exactly 1 cycle): uart_write_o=1, ack_o[g]=1. Requester may change data/drop req after ack.
//   -> WAIT_BUSY, timeout counter cleared.
//  WAIT_BUSY: uart_write_o=0. uart_busy_i=1 -> WAIT_DONE. Counter increments each cycle;
//   counter==BUSY_TIMEOUT with busy still 0 -> error_o pulse, rr_ptr=g+1, -> IDLE.
//  WAIT_DONE: on uart_busy_i=0: done_o pulse this cycle, then
//   lock_i[g] && req_i[g] -> ISSUE directly (data_i[g] re-latched, rr_ptr unchanged);
//   else rr_ptr=(g+1) mod NUM_REQ, -> IDLE.
//  Latency: req in IDLE at cycle T -> uart_write_o at T+1; back-to-back locked bytes: write pulse
//   1 cycle after busy falls. Unlocked byte to next grant: 2 cycles after busy falls.
//  Simultaneous requests: round-robin only; no fixed priority. Lock ignored if req_i[g] low.
//  req_i changes while not granted: no effect until IDLE. Out-of-range rr_ptr wrap: g+1==NUM_REQ -> 0.
//  Illegal state encoding -> IDLE. ack_o is one-hot or zero, never multi-bit.
// STRUCTURE
//  Shared include uart_defs.vh: state localparams (IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3),
//   byte width localparam; reused by future uart_rx sequencers.
//  One sub-module: rr_arbiter (combinational rotate-priority picker: req, rr_ptr -> valid, index).
//  FSM, timeout counter, data/grant registers in this module.
// TESTING
//  Single req_i=4'b0001, data 8'h55, busy model rises 2 cycles after write, 100 cycles busy ->
//   one write pulse, uart_data_o=8'h55 held, ack_o=0001 once, done_o once when busy falls.
//  req_i=4'b1111 constant, no lock -> grant order 0,1,2,3,0; one write per byte; ack one-hot.
//  lock_i[2]=1, req_i[2] held for 3 bytes (8'hA1,A2,A3) while req_i[0]=1 -> three bytes from 2
//   back-to-back, then requester 0 granted.
//  Busy never rises (tied 0) -> error_o pulse 16 cycles after write, IDLE, next requester granted.
//  reset_n_i low during WAIT_DONE -> all outputs 0 same cycle; after release with req_i=0001,
//   grant starts at index 0 (rr_ptr reset).
//  uart_busy_i held high in IDLE with req_i=0010 -> no write until busy low, then write next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, byte width and
// the round-robin successor helper.
package uart_tx_arbiter_pkg;

  localparam int unsigned ByteWidth = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } state_e;

  // Requester after idx in round-robin order, wrapping to 0 at num_req.
  function automatic int unsigned next_index(int unsigned idx, int unsigned num_req);
    return (idx + 1 >= num_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UartTx-side signals of the UART transmit arbiter.
// master: the arbiter itself; slave: requesters plus the UartTx instance.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned INDEX_WIDTH = 2
);
  logic [NUM_REQ-1:0]                                req_i;
  logic [NUM_REQ-1:0]                                lock_i;
  logic [uart_tx_arbiter_pkg::ByteWidth*NUM_REQ-1:0] data_i;
  logic [NUM_REQ-1:0]                                ack_o;
  logic                                              done_o;
  logic                                              error_o;
  logic                                              active_o;
  logic [INDEX_WIDTH-1:0]                            grant_index_o;
  logic                                              uart_write_o;
  logic [uart_tx_arbiter_pkg::ByteWidth-1:0]         uart_data_o;
  logic                                              uart_busy_i;

  modport master (
    input  req_i, lock_i, data_i, uart_busy_i,
    output ack_o, done_o, error_o, active_o, grant_index_o, uart_write_o, uart_data_o
  );

  modport slave (
    output req_i, lock_i, data_i, uart_busy_i,
    input  ack_o, done_o, error_o, active_o, grant_index_o, uart_write_o, uart_data_o
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker: first requester at or after rr_ptr_i,
// wrapping around to index 0.
module uart_tx_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned INDEX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [INDEX_WIDTH-1:0] rr_ptr_i,
  output logic                   valid_o,
  output logic [INDEX_WIDTH-1:0] index_o
);

  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    // Pass 1 covers rr_ptr..NUM_REQ-1, pass 2 the wrapped part 0..rr_ptr-1.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!valid_o && req_i[k] && (k >= 32'(rr_ptr_i))) begin
        valid_o = 1'b1;
        index_o = INDEX_WIDTH'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!valid_o && req_i[k] && (k < 32'(rr_ptr_i))) begin
        valid_o = 1'b1;
        index_o = INDEX_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UartTx between NUM_REQ byte producers: round-robin grant per byte,
// optional lock for multi-byte messages, and the write/busy-rise/busy-fall handshake.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned INDEX_WIDTH   = 2,
  parameter int unsigned BUSY_TIMEOUT  = 15,
  parameter int unsigned TIMEOUT_WIDTH = 4
) (
  input logic               clock_i,
  input logic               reset_n_i,
  uart_tx_arbiter_if.master bus
);

  state_e                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [INDEX_WIDTH-1:0]   grant_q, grant_d;
  logic [ByteWidth-1:0]     data_q, data_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  logic                     pick_valid;
  logic [INDEX_WIDTH-1:0]   pick_index;
  logic [INDEX_WIDTH-1:0]   src_idx;
  logic [NUM_REQ-1:0]       grant_oh;
  logic [ByteWidth-1:0]     sel_data;
  logic                     lock_hold;
  logic [INDEX_WIDTH-1:0]   rr_next;

  logic [NUM_REQ-1:0]       ack;
  logic                     write, done, error;

  uart_tx_arbiter_rr_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_rr_arbiter (
    .req_i    (bus.req_i),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .index_o  (pick_index)
  );

  // Byte source is the fresh pick in idle, otherwise the held grant (lock re-latch).
  always_comb begin
    grant_oh = '0;
    sel_data = '0;
    src_idx  = (state_q == StIdle) ? pick_index : grant_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (INDEX_WIDTH'(k) == grant_q) grant_oh[k] = 1'b1;
      if (INDEX_WIDTH'(k) == src_idx) sel_data = bus.data_i[ByteWidth*k +: ByteWidth];
    end
  end

  assign lock_hold = |(bus.lock_i & bus.req_i & grant_oh);
  assign rr_next   = INDEX_WIDTH'(next_index(32'(grant_q), NUM_REQ));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    ack      = '0;
    write    = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid && !bus.uart_busy_i) begin
          grant_d = pick_index;
          data_d  = sel_data;
          state_d = StIssue;
        end
      end
      StIssue: begin
        write   = 1'b1;
        ack     = grant_oh;
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.uart_busy_i) begin
          state_d = StWaitDone;
        end else if (cnt_q == TIMEOUT_WIDTH'(BUSY_TIMEOUT)) begin
          error    = 1'b1;
          rr_ptr_d = rr_next;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!bus.uart_busy_i) begin
          done = 1'b1;
          if (lock_hold) begin
            data_d  = sel_data;
            state_d = StIssue;
          end else begin
            rr_ptr_d = rr_next;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ack_o         = ack;
  assign bus.done_o        = done;
  assign bus.error_o       = error;
  assign bus.active_o      = (state_q != StIdle);
  assign bus.grant_index_o = grant_q;
  assign bus.uart_write_o  = write;
  assign bus.uart_data_o   = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter with a behavioural UartTx and
// per-requester byte queues; expected grant order comes from a round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned NReq    = 4;
  localparam int unsigned IdxW    = 2;
  localparam int unsigned Timeout = 15;
  localparam int          Bound   = 3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NReq), .INDEX_WIDTH(IdxW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (NReq),
    .INDEX_WIDTH   (IdxW),
    .BUSY_TIMEOUT  (Timeout),
    .TIMEOUT_WIDTH (4)
  ) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
    bit         err;
    int         gap;  // cycles from previous done/error pulse to this write; 0 = unchecked
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic [7:0] rq_data[NReq][8];
  int         rq_cnt[NReq];
  int         rq_pos[NReq];
  bit         rq_lock[NReq];
  bit         ext_hold  = 1'b0;
  bit         no_busy   = 1'b0;
  int         rise_cnt  = 0;
  int         busy_cnt  = 0;
  int         m_ptr     = 0;
  bit         in_flight = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Requesters and UartTx model: all driving happens at the falling edge.
  initial begin : env
    for (int k = 0; k < NReq; k++) begin
      rq_cnt[k]  = 0;
      rq_pos[k]  = 0;
      rq_lock[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rise_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < NReq; k++) begin
          rq_cnt[k] = 0;
          rq_pos[k] = 0;
        end
      end else begin
        for (int k = 0; k < NReq; k++)
          if (bus.ack_o[k] && rq_pos[k] < rq_cnt[k]) rq_pos[k]++;
        if (bus.uart_write_o) begin
          if (!no_busy) rise_cnt = 1 + int'($urandom_range(2));
        end else if (rise_cnt > 0) begin
          rise_cnt--;
          if (rise_cnt == 0) busy_cnt = 2 + int'($urandom_range(4));
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
      end
      bus.uart_busy_i = ext_hold || (busy_cnt > 0);
      for (int k = 0; k < NReq; k++) begin
        bus.req_i[k]          = (rq_pos[k] < rq_cnt[k]);
        bus.lock_i[k]         = rq_lock[k];
        bus.data_i[8*k +: 8]  = (rq_pos[k] < 8) ? rq_data[k][rq_pos[k]] : 8'h00;
      end
    end
  end

  // Monitor: samples 2 time units after the falling edge and checks against the queue.
  initial begin : mon
    int   cyc;
    int   write_cyc;
    int   last_end;
    bit   prev_busy;
    bit   wr;
    exp_t e;
    exp_t cur;
    cyc = 0; write_cyc = 0; last_end = 0; prev_busy = 1'b0;
    cur = '{0, 8'h00, 1'b0, 0};
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        check(bus.ack_o == '0 && !bus.done_o && !bus.error_o && !bus.active_o &&
              bus.grant_index_o == '0 && !bus.uart_write_o && bus.uart_data_o == 8'h00,
              "reset_outputs",
              int'({bus.ack_o, bus.done_o, bus.error_o, bus.active_o, bus.grant_index_o,
                    bus.uart_write_o, bus.uart_data_o}), 0);
        in_flight = 1'b0;
        exp_q.delete();
        prev_busy = 1'b0;
      end else begin
        wr = bus.uart_write_o;
        check(bus.active_o == (wr || in_flight), "active", int'(bus.active_o),
              int'(wr || in_flight));
        if (wr) begin
          check(!prev_busy, "write_needs_busy_low", int'(prev_busy), 0);
          check(exp_q.size() != 0, "write_expected", exp_q.size(), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(bus.ack_o == 4'(1 << e.idx), "ack_onehot", int'(bus.ack_o), 1 << e.idx);
            check(int'(bus.grant_index_o) == e.idx, "grant_index", int'(bus.grant_index_o),
                  e.idx);
            check(bus.uart_data_o == e.data, "write_data", int'(bus.uart_data_o),
                  int'(e.data));
            if (e.gap != 0)
              check(cyc - last_end == e.gap, "write_latency", cyc - last_end, e.gap);
            cur       = e;
            in_flight = 1'b1;
            write_cyc = cyc;
          end
        end else begin
          check(bus.ack_o == '0, "ack_without_write", int'(bus.ack_o), 0);
          if (in_flight)
            check(bus.uart_data_o == cur.data, "data_stable", int'(bus.uart_data_o),
                  int'(cur.data));
        end
        if (bus.done_o || bus.error_o) begin
          check(in_flight, "end_pulse_in_flight", int'(in_flight), 1);
          if (in_flight) begin
            check(bus.done_o == !cur.err && bus.error_o == cur.err, "end_kind",
                  int'({bus.done_o, bus.error_o}), int'({!cur.err, cur.err}));
            if (cur.err)
              check(cyc - write_cyc == Timeout + 1, "timeout_latency", cyc - write_cyc,
                    Timeout + 1);
            else
              check(prev_busy && !bus.uart_busy_i, "done_on_busy_fall",
                    int'({prev_busy, bus.uart_busy_i}), 2);
            last_end  = cyc;
            in_flight = 1'b0;
          end
        end
        prev_busy = bus.uart_busy_i;
      end
    end
  end

  // Load one burst of bytes while busy is forced high, predict the full output sequence,
  // then release busy. all_req gives every requester at least one byte.
  task automatic load_round(input bit err_mode, input bit all_req);
    int cnt[NReq];
    int total, ptr, g, hold, c;
    bit first;
    @(negedge clk); #1;
    ext_hold = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    no_busy = err_mode;
    total   = 0;
    for (int k = 0; k < NReq; k++) begin
      cnt[k]     = all_req ? 1 + int'($urandom_range(2)) : int'($urandom_range(3));
      rq_lock[k] = 1'($urandom_range(1));
      rq_pos[k]  = 0;
      for (int j = 0; j < 8; j++) rq_data[k][j] = 8'($urandom);
    end
    if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) cnt[$urandom_range(NReq - 1)] = 2;
    for (int k = 0; k < NReq; k++) begin
      rq_cnt[k] = cnt[k];
      total += cnt[k];
    end
    ptr = m_ptr; hold = -1; first = 1'b1;
    while (total > 0) begin
      if (hold >= 0) begin
        g = hold;
      end else begin
        g = -1;
        for (int i = 0; i < NReq; i++) begin
          c = (ptr + i) % NReq;
          if (g < 0 && cnt[c] > 0) g = c;
        end
      end
      exp_q.push_back('{g, rq_data[g][rq_cnt[g] - cnt[g]], err_mode,
                        first ? 0 : ((hold >= 0) ? 1 : 2)});
      cnt[g]--;
      total--;
      first = 1'b0;
      if (!err_mode && rq_lock[g] && cnt[g] > 0) begin
        hold = g;
      end else begin
        hold = -1;
        ptr  = (g + 1) % NReq;
      end
    end
    m_ptr = ptr;
    repeat (3) begin @(negedge clk); #1; end
    ext_hold = 1'b0;
  endtask

  task automatic wait_drain(output bit timed_out);
    int n;
    n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while (!(exp_q.size() == 0 && !in_flight && !bus.active_o) && n < Bound);
    check(n < Bound, "drain_within_bound", n, Bound);
    timed_out = (n >= Bound);
  endtask

  initial begin : main
    bit abort;
    int n;
    abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    load_round(1'b0, 1'b1);
    wait_drain(abort);
    for (int r = 0; r < 30 && !abort; r++) begin
      load_round(r % 6 == 5, 1'b0);
      wait_drain(abort);
    end

    // Two unlocked bytes from requester 1; reset lands while the second is in WAIT_DONE.
    if (!abort) begin
      @(negedge clk); #1;
      no_busy = 1'b0;
      for (int k = 0; k < NReq; k++) begin
        rq_cnt[k] = 0; rq_pos[k] = 0; rq_lock[k] = 1'b0;
      end
      rq_data[1][0] = 8'h3C;
      rq_data[1][1] = 8'hC3;
      rq_cnt[1]     = 2;
      exp_q.push_back('{1, 8'h3C, 1'b0, 0});
      exp_q.push_back('{1, 8'hC3, 1'b0, 2});
      n = 0;
      do begin
        @(negedge clk); #3;
        n++;
      end while (!(exp_q.size() == 0 && in_flight && bus.uart_busy_i) && n < Bound);
      check(n < Bound, "second_byte_busy", n, Bound);
      @(negedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      m_ptr = 0;
      load_round(1'b0, 1'b1);
      wait_drain(abort);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
